pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the multi-cycle MIPS core. It generalises the next-instruction unit with:
- a configurable phase count per instruction;
- an optional branch delay slot;
- encoded branch/jump operations;
- MIPS-correct jump-region addressing;
- an exception redirect with EPC capture.

It sits between the decoder/register file (operand and opcode inputs) and the fetch path (PC output, phase output) and the register-file link write port.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/br_resolve.sv | 50 +++++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int PHASE_W = 2;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;

  // Encodings 13..15 are unused and resolve as BR_NONE.
  typedef enum logic [3:0] {
    BR_NONE   = 4'd0,
    BR_J      = 4'd1,
    BR_JAL    = 4'd2,
    BR_JR     = 4'd3,
    BR_JALR   = 4'd4,
    BR_BEQ    = 4'd5,
    BR_BNE    = 4'd6,
    BR_BGEZ   = 4'd7,
    BR_BGEZAL = 4'd8,
    BR_BGTZ   = 4'd9,
    BR_BLEZ   = 4'd10,
    BR_BLTZ   = 4'd11,
    BR_BLTZAL = 4'd12
  } br_op_t;

endpackage

// File: rtl/br_resolve.sv
// Combinational branch/jump resolution: taken flag, redirect target and link request.
module br_resolve
  import pc_seq_pkg::*;
(
  input  logic [3:0]  br_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] pc,
  output logic        taken,
  output logic [31:0] target,
  output logic        is_link
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        rs_neg;
  logic        rs_zero;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_plus4[31:28], target26, 2'b00};
  // Signed compares against zero reduce to the sign bit and a zero test.
  assign rs_neg    = rs[31];
  assign rs_zero   = (rs == 32'd0);

  always_comb begin
    taken   = 1'b0;
    target  = br_target;
    is_link = 1'b0;
    case (br_op)
      BR_J:      begin taken = 1'b1; target = j_target; end
      BR_JAL:    begin taken = 1'b1; target = j_target; is_link = 1'b1; end
      BR_JR:     begin taken = 1'b1; target = rs; end
      BR_JALR:   begin taken = 1'b1; target = rs; is_link = 1'b1; end
      BR_BEQ:    taken = (rs == rt);
      BR_BNE:    taken = (rs != rt);
      BR_BGEZ:   taken = !rs_neg;
      BR_BGEZAL: begin taken = !rs_neg; is_link = 1'b1; end
      BR_BGTZ:   taken = !rs_neg && !rs_zero;
      BR_BLEZ:   taken = rs_neg || rs_zero;
      BR_BLTZ:   taken = rs_neg;
      BR_BLTZAL: begin taken = rs_neg; is_link = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: phase counter, PC/next-PC tracking,
// optional branch delay slot and exception redirect with EPC capture.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          NUM_PHASES   = 3,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [3:0]         br_op,
  input  logic [31:0]        rs,
  input  logic [31:0]        rt,
  input  logic [15:0]        imm16,
  input  logic [25:0]        target26,
  input  logic               exc_req,
  output logic [31:0]        pc,
  output logic [PHASE_W-1:0] phase,
  output logic               commit,
  output logic               link_we,
  output logic [31:0]        link_data,
  output logic               in_delay_slot,
  output logic [31:0]        epc
);

  localparam logic [PHASE_W-1:0] COMMIT_PHASE = PHASE_W'(NUM_PHASES - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pc_next_q, pc_next_d;
  logic               ids_q, ids_d;
  logic [31:0]        epc_q, epc_d;

  logic               taken;
  logic [31:0]        target;
  logic               is_link;

  br_resolve u_br_resolve (
    .br_op    (br_op),
    .rs       (rs),
    .rt       (rt),
    .imm16    (imm16),
    .target26 (target26),
    .pc       (pc_q),
    .taken    (taken),
    .target   (target),
    .is_link  (is_link)
  );

  assign commit    = (phase_q == COMMIT_PHASE) && !stall;
  assign link_we   = commit && is_link && !exc_req;
  assign link_data = pc_q + (DELAY_SLOT ? 32'd8 : 32'd4);

  always_comb begin
    phase_d   = phase_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    ids_d     = ids_q;
    epc_d     = epc_q;
    if (!stall) begin
      phase_d = (phase_q == COMMIT_PHASE) ? '0 : phase_q + 1'b1;
    end
    if (commit) begin
      if (exc_req) begin
        // Restart at the branch when the faulting instruction sits in its delay slot.
        pc_d      = EXC_VECTOR;
        pc_next_d = EXC_VECTOR + 32'd4;
        epc_d     = ids_q ? pc_q - 32'd4 : pc_q;
        ids_d     = 1'b0;
      end else if (DELAY_SLOT) begin
        pc_d      = pc_next_q;
        pc_next_d = taken ? target : pc_next_q + 32'd4;
        ids_d     = taken;
      end else begin
        pc_d      = taken ? target : pc_q + 32'd4;
        pc_next_d = pc_d + 32'd4;
        ids_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= '0;
      pc_q      <= RESET_VECTOR;
      pc_next_q <= RESET_VECTOR + 32'd4;
      ids_q     <= 1'b0;
      epc_q     <= 32'd0;
    end else begin
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      ids_q     <= ids_d;
      epc_q     <= epc_d;
    end
  end

  assign pc            = pc_q;
  assign phase         = phase_q;
  assign in_delay_slot = ids_q;
  assign epc           = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: one delay-slot and one immediate-redirect instance
// share stimulus and are checked every cycle against an instruction-level model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int          NP  = 3;
  localparam logic [31:0] RV  = 32'hBFC0_0000;
  localparam logic [31:0] EXV = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  br_op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] target26 = 26'd0;
  logic        exc_req = 1'b0;

  // Index 1: DELAY_SLOT=1 instance, index 0: DELAY_SLOT=0 instance.
  logic [31:0] pc_o [2];
  logic [1:0]  ph_o [2];
  logic        cm_o [2];
  logic        lw_o [2];
  logic [31:0] ld_o [2];
  logic        ids_o [2];
  logic [31:0] epc_o [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_commit1 = 0;
  int cnt_link1 = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXV), .NUM_PHASES(NP), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .rst(rst), .stall(stall), .br_op(br_op), .rs(rs), .rt(rt), .imm16(imm16),
    .target26(target26), .exc_req(exc_req), .pc(pc_o[1]), .phase(ph_o[1]), .commit(cm_o[1]),
    .link_we(lw_o[1]), .link_data(ld_o[1]), .in_delay_slot(ids_o[1]), .epc(epc_o[1])
  );

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXV), .NUM_PHASES(NP), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .rst(rst), .stall(stall), .br_op(br_op), .rs(rs), .rt(rt), .imm16(imm16),
    .target26(target26), .exc_req(exc_req), .pc(pc_o[0]), .phase(ph_o[0]), .commit(cm_o[0]),
    .link_we(lw_o[0]), .link_data(ld_o[0]), .in_delay_slot(ids_o[0]), .epc(epc_o[0])
  );

  typedef struct packed {
    logic        tk;
    logic [31:0] tg;
    logic        lk;
  } res_t;

  function automatic res_t resolve(input logic [3:0] op, input logic [31:0] s, input logic [31:0] t,
                                   input logic [15:0] im, input logic [25:0] j, input logic [31:0] p);
    res_t r;
    int   si;
    int   off;
    si   = int'($signed(s));
    off  = int'($signed(im));
    r.tk = 1'b0;
    r.lk = 1'b0;
    r.tg = p + 32'd4 + 32'(off * 4);
    case (op)
      BR_J:      begin r.tk = 1'b1; r.tg = ((p + 32'd4) & 32'hF000_0000) | {4'd0, j, 2'b00}; end
      BR_JAL:    begin r.tk = 1'b1; r.lk = 1'b1; r.tg = ((p + 32'd4) & 32'hF000_0000) | {4'd0, j, 2'b00}; end
      BR_JR:     begin r.tk = 1'b1; r.tg = s; end
      BR_JALR:   begin r.tk = 1'b1; r.lk = 1'b1; r.tg = s; end
      BR_BEQ:    r.tk = (s == t);
      BR_BNE:    r.tk = (s != t);
      BR_BGEZ:   r.tk = (si >= 0);
      BR_BGEZAL: begin r.tk = (si >= 0); r.lk = 1'b1; end
      BR_BGTZ:   r.tk = (si > 0);
      BR_BLEZ:   r.tk = (si <= 0);
      BR_BLTZ:   r.tk = (si < 0);
      BR_BLTZAL: begin r.tk = (si < 0); r.lk = 1'b1; end
      default:   ;
    endcase
    return r;
  endfunction

  // Instruction-level model: current pc plus a pending redirect for the delay-slot variant.
  int          m_phase = 0;
  logic [31:0] m_pc [2]     = '{RV, RV};
  logic        m_pend_v [2] = '{1'b0, 1'b0};
  logic [31:0] m_pend [2]   = '{32'd0, 32'd0};
  logic        m_ids [2]    = '{1'b0, 1'b0};
  logic [31:0] m_epc [2]    = '{32'd0, 32'd0};
  res_t        m_res [2];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      m_res[d] = resolve(br_op, rs, rt, imm16, target26, m_pc[d]);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      for (int d = 0; d < 2; d++) begin
        m_pc[d] <= RV; m_pend_v[d] <= 1'b0; m_ids[d] <= 1'b0; m_epc[d] <= 32'd0;
      end
    end else if (!stall) begin
      if (m_phase == NP - 1) begin
        for (int d = 0; d < 2; d++) begin
          if (exc_req) begin
            m_epc[d]    <= m_ids[d] ? m_pc[d] - 32'd4 : m_pc[d];
            m_pc[d]     <= EXV;
            m_pend_v[d] <= 1'b0;
            m_ids[d]    <= 1'b0;
          end else if (d == 1) begin
            m_pc[d]     <= m_pend_v[d] ? m_pend[d] : m_pc[d] + 32'd4;
            m_pend_v[d] <= m_res[d].tk;
            m_pend[d]   <= m_res[d].tg;
            m_ids[d]    <= m_res[d].tk;
          end else begin
            m_pc[d] <= m_res[d].tk ? m_res[d].tg : m_pc[d] + 32'd4;
          end
        end
      end
      m_phase <= (m_phase + 1) % NP;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_commit;
    exp_commit = rst && (m_phase == NP - 1) && !stall;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ds%0d.pc", d), pc_o[d], m_pc[d]);
      chk($sformatf("ds%0d.phase", d), 32'(ph_o[d]), 32'(m_phase));
      chk($sformatf("ds%0d.commit", d), 32'(cm_o[d]), 32'(exp_commit));
      chk($sformatf("ds%0d.link_we", d), 32'(lw_o[d]), 32'(exp_commit && m_res[d].lk && !exc_req));
      chk($sformatf("ds%0d.link_data", d), ld_o[d], m_pc[d] + 32'(4 * (d + 1)));
      chk($sformatf("ds%0d.in_delay_slot", d), 32'(ids_o[d]), 32'(d == 1 && m_ids[d]));
      chk($sformatf("ds%0d.epc", d), epc_o[d], m_epc[d]);
    end
    if (cm_o[1]) cnt_commit1++;
    if (lw_o[1]) cnt_link1++;
  end

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input logic [3:0] op, input logic [31:0] s, input logic [31:0] t,
                         input logic [15:0] im, input logic [25:0] j, input logic e);
    br_op = op; rs = s; rt = t; imm16 = im; target26 = j; exc_req = e;
  endtask

  task automatic instr(input logic [3:0] op, input logic [31:0] s, input logic [31:0] t,
                       input logic [15:0] im, input logic [25:0] j);
    set_ops(op, s, t, im, j, 1'b0);
    run_cycles(NP);
    $display("instr op=%0d rs=%h rt=%h imm=%h t26=%h -> pc1=%h pc0=%h", op, s, t, im, j, pc_o[1], pc_o[0]);
  endtask

  task automatic do_reset();
    set_ops(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
    stall = 1'b0;
    rst = 1'b0;
    run_cycles(2);
    rst = 1'b1;
  endtask

  int c0;
  int l0;

  initial begin
    // BEQ taken at reset vector
    do_reset();
    chk("reset.pc", pc_o[1], 32'hBFC0_0000);
    chk("reset.phase", 32'(ph_o[1]), 32'd0);
    instr(BR_BEQ, 32'd5, 32'd5, 16'h0004, 26'd0);
    chk("beq.ds1.pc", pc_o[1], 32'hBFC0_0004);
    chk("beq.ds0.pc", pc_o[0], 32'hBFC0_0014);
    chk("beq.phase", 32'(ph_o[1]), 32'd0);
    instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    chk("beq.ds1.pc2", pc_o[1], 32'hBFC0_0014);

    // J into the 0xB region
    do_reset();
    repeat (4) instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    instr(BR_J, 32'd0, 32'd0, 16'd0, 26'h000_0100);
    chk("j.ds1.slot", pc_o[1], 32'hBFC0_0014);
    chk("j.ds0.pc", pc_o[0], 32'hB000_0400);
    instr(4'hF, 32'd0, 32'd0, 16'd0, 26'd0);
    chk("j.ds1.pc", pc_o[1], 32'hB000_0400);

    // Stall in phase 1
    set_ops(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
    run_cycles(1);
    stall = 1'b1;
    c0 = cnt_commit1;
    run_cycles(5);
    chk("stall.phase", 32'(ph_o[1]), 32'd1);
    chk("stall.pc", pc_o[1], 32'hB000_0400);
    chk("stall.no_commit", 32'(cnt_commit1 - c0), 32'd0);
    stall = 1'b0;
    run_cycles(2);
    chk("stall.one_commit", 32'(cnt_commit1 - c0), 32'd1);
    chk("stall.pc_after", pc_o[1], 32'hB000_0404);

    // BLTZAL taken with link, BGEZ not taken in its delay slot, then JR wrap
    do_reset();
    repeat (8) instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    l0 = cnt_link1;
    set_ops(BR_BLTZAL, 32'hFFFF_FFFF, 32'd0, 16'h0010, 26'd0, 1'b0);
    run_cycles(NP - 1);
    chk("bltzal.link_we", 32'(lw_o[1]), 32'd1);
    chk("bltzal.link_data", ld_o[1], 32'hBFC0_0028);
    run_cycles(1);
    chk("bltzal.one_link", 32'(cnt_link1 - l0), 32'd1);
    chk("bltzal.ds0.pc", pc_o[0], 32'hBFC0_0064);
    instr(BR_BGEZ, 32'h8000_0000, 32'd0, 16'h0010, 26'd0);
    chk("bgez.ds1.pc", pc_o[1], 32'hBFC0_0064);
    chk("bgez.ds0.pc", pc_o[0], 32'hBFC0_0068);
    instr(BR_JR, 32'hFFFF_FFFC, 32'd0, 16'd0, 26'd0);
    chk("jr.ds1.slot", pc_o[1], 32'hBFC0_0068);
    instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    chk("jr.ds1.pc", pc_o[1], 32'hFFFF_FFFC);
    instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    chk("wrap.ds1.pc", pc_o[1], 32'h0000_0000);

    // Exception in the delay slot of a taken branch
    do_reset();
    repeat (16) instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    instr(BR_BEQ, 32'd0, 32'd0, 16'h0010, 26'd0);
    chk("exc.ds1.slot_pc", pc_o[1], 32'hBFC0_0044);
    set_ops(BR_JAL, 32'd0, 32'd0, 16'd0, 26'd1, 1'b1);
    run_cycles(NP - 1);
    chk("exc.link_we", 32'(lw_o[1]), 32'd0);
    run_cycles(1);
    exc_req = 1'b0;
    chk("exc.ds1.epc", epc_o[1], 32'hBFC0_0040);
    chk("exc.ds1.pc", pc_o[1], 32'hBFC0_0380);
    chk("exc.ds0.epc", epc_o[0], 32'hBFC0_0084);
    chk("exc.ds0.pc", pc_o[0], 32'hBFC0_0380);

    // Async reset mid delay slot with a taken branch pending
    instr(BR_BEQ, 32'd7, 32'd7, 16'h0020, 26'd0);
    chk("rst.pre_ids", 32'(ids_o[1]), 32'd1);
    set_ops(BR_BEQ, 32'd7, 32'd7, 16'h0020, 26'd0, 1'b0);
    run_cycles(NP - 1);
    rst = 1'b0;
    #1;
    chk("rst.async.pc", pc_o[1], 32'hBFC0_0000);
    chk("rst.async.phase", 32'(ph_o[1]), 32'd0);
    chk("rst.async.ids", 32'(ids_o[1]), 32'd0);
    chk("rst.async.epc", epc_o[1], 32'd0);
    run_cycles(1);
    rst = 1'b1;
    instr(BR_NONE, 32'd0, 32'd0, 16'd0, 26'd0);
    chk("rst.after.pc", pc_o[1], 32'hBFC0_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
